md_seq: RTL and testbench

- Multi-cycle sequencer for the E-stage multiply/divide resource of the pipelined MIPS core.
- Accepts one md operation per issue, computes it, and holds the result for the configured latency, mimicking the 5/10-cycle hardware timing.
- Commits HI/LO at the end of that latency and drives `busy` to the hazard unit as e_md_busy.
- Serves mfhi/mflo reads and mthi/mtlo writes.

---
 rtl/md_seq_pkg.sv | 22 ++
 rtl/md_arith.sv | 68 ++++++
 rtl/md_seq.sv | 96 +++++++++
 tb/tb_md_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_seq_pkg.sv
// Shared encodings for the E-stage multiply/divide sequencer.
// Holds MD_* opcodes, FSM state codes and default latencies.
package md_seq_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_MUL  = 2'd1;
    localparam logic [1:0] MD_DIV_ST = 2'd2;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational mult/div datapath for md_seq.
// Ports: op, a, b in; hi_n, lo_n (result), wr (result is to be written) out.
module md_arith
    import md_seq_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        wr
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] b_s;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;
    logic        b_m1;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    // Divisor forced nonzero so the divider never sees /0;
    // the zero case is flagged via wr instead.
    assign b_s  = (b == 32'd0) ? 32'd1 : b;
    assign b_m1 = (b == 32'hFFFF_FFFF);

    assign uq = a / b_s;
    assign ur = a % b_s;

    // x / -1 is negation; handled apart so INT_MIN / -1 wraps
    // to INT_MIN rather than overflowing the signed divider.
    assign sq = b_m1 ? (32'd0 - a)
                     : 32'($signed(a) / $signed(b_s));
    assign sr = b_m1 ? 32'd0
                     : 32'($signed(a) % $signed(b_s));

    always_comb begin
        hi_n = 32'd0;
        lo_n = 32'd0;
        wr   = 1'b0;
        unique case (1'b1)
            (op == MD_MULT): begin
                {hi_n, lo_n} = sprod;
                wr = 1'b1;
            end
            (op == MD_MULTU): begin
                {hi_n, lo_n} = uprod;
                wr = 1'b1;
            end
            (op == MD_DIV): begin
                hi_n = sr;
                lo_n = sq;
                wr   = (b != 32'd0);
            end
            (op == MD_DIVU): begin
                hi_n = ur;
                lo_n = uq;
                wr   = (b != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_seq.sv
// Multi-cycle HI/LO sequencer for the E-stage md resource.
// Ports: clk, rst, op, a, b in; busy, hi, lo, rdata out.
module md_seq
    import md_seq_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int CW = 16;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_wr;

    logic [31:0]   hi_n;
    logic [31:0]   lo_n;
    logic          wr_n;

    md_arith u_arith (
        .op   (op),
        .a    (a),
        .b    (b),
        .hi_n (hi_n),
        .lo_n (lo_n),
        .wr   (wr_n)
    );

    assign busy = (state != MD_IDLE);

    always_comb begin
        rdata = 32'd0;
        unique case (1'b1)
            (op == MD_MFHI): rdata = hi;
            (op == MD_MFLO): rdata = lo;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (state == MD_IDLE) begin
            unique case (1'b1)
                (op == MD_MULT),
                (op == MD_MULTU): begin
                    pend_hi <= hi_n;
                    pend_lo <= lo_n;
                    pend_wr <= wr_n;
                    cnt     <= CW'(MULT_CYCLES - 1);
                    state   <= MD_MUL;
                end
                (op == MD_DIV),
                (op == MD_DIVU): begin
                    pend_hi <= hi_n;
                    pend_lo <= lo_n;
                    pend_wr <= wr_n;
                    cnt     <= CW'(DIV_CYCLES - 1);
                    state   <= MD_DIV_ST;
                end
                (op == MD_MTHI): hi <= a;
                (op == MD_MTLO): lo <= a;
                default: ;
            endcase
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            // Commit edge: still busy here, so no new op is
            // accepted until the following edge.
            if (pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            state <= MD_IDLE;
        end
    end

endmodule

// File: tb/tb_md_seq.sv
// Scoreboard bench for md_seq: directed ops, monitor checks
// busy length and committed HI/LO on every busy fall.
module tb_md_seq;
    import md_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  op  = MD_NONE;
    logic [31:0] a   = 32'd0;
    logic [31:0] b   = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    md_seq dut (
        .clk   (clk),
        .rst   (rst),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: runs of busy measured on the falling clock edge.
    initial begin : monitor
        int   run;
        logic prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run  = 0;
                prev = 1'b0;
            end else if (busy) begin
                run++;
                prev = 1'b1;
            end else begin
                if (prev) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_commit: hi %h lo %h",
                                 hi, lo);
                    end else begin
                        e = q.pop_front();
                        chk("busy_len", 32'(run), 32'(e.len));
                        chk("commit_hi", hi, e.hi);
                        chk("commit_lo", lo, e.lo);
                    end
                end
                run  = 0;
                prev = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy %b want 0", busy);
        end
        @(negedge clk);
        #1;
        step();
    endtask

    task automatic issue(input logic [3:0] o,
                         input logic [31:0] av,
                         input logic [31:0] bv,
                         input logic [31:0] eh,
                         input logic [31:0] el,
                         input int len,
                         input bit push);
        exp_t e;
        op = o;
        a  = av;
        b  = bv;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.len = len;
            q.push_back(e);
        end
        step();
        op = MD_NONE;
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Async reset without a clock edge.
        issue(MD_MTHI, 32'h55, 32'd0, 0, 0, 0, 0);
        issue(MD_MTLO, 32'h66, 32'd0, 0, 0, 0, 0);
        chk("mthi", hi, 32'h55);
        chk("mtlo", lo, 32'h66);
        #2 rst = 1'b1;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        step();
        rst = 1'b0;

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1);
        wait_idle();
        op = MD_MFHI;
        #1 chk("mfhi", rdata, 32'hFFFF_FFFF);
        op = MD_MFLO;
        #1 chk("mflo", rdata, 32'hFFFF_FFFA);
        op = MD_NONE;
        #1 chk("rdata_none", rdata, 32'd0);

        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3,
              32'h0000_0002, 32'hFFFF_FFFA, 5, 1);
        wait_idle();

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1);
        wait_idle();

        issue(MD_DIVU, 32'd7, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1);
        wait_idle();

        issue(MD_DIVU, 32'd100, 32'd7,
              32'd2, 32'd14, 10, 1);
        wait_idle();

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'd0, 32'h8000_0000, 10, 1);
        wait_idle();

        // Ops while busy are ignored; mfhi sees old hi.
        issue(MD_MULT, 32'd6, 32'd7, 32'd0, 32'h2A, 5, 1);
        step();
        step();
        op = MD_MFHI;
        #1 chk("mfhi_busy", rdata, 32'd0);
        chk("busy_c3", 32'(busy), 32'd1);
        op = MD_MTLO;
        a  = 32'h1234;
        step();
        op = MD_MULT;
        a  = 32'd100;
        b  = 32'd100;
        step();
        op = MD_NONE;
        wait_idle();
        step();
        chk("no_second", 32'(busy), 32'd0);
        chk("lo_kept", lo, 32'h2A);

        // Reset during a DIV discards it.
        issue(MD_DIV, 32'd100, 32'd7, 0, 0, 0, 0);
        step();
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        @(negedge clk);
        step();
        rst = 1'b0;
        repeat (12) step();
        chk("no_commit_hi", hi, 32'd0);
        chk("no_commit_lo", lo, 32'd0);
        op = MD_MTHI;
        a  = 32'hDEAD;
        step();
        op = MD_NONE;
        chk("mthi_dead", hi, 32'hDEAD);
        chk("mthi_busy", 32'(busy), 32'd0);

        // Back-to-back MULT held on op.
        begin
            exp_t e;
            e.hi  = 32'd0;
            e.lo  = 32'd15;
            e.len = 5;
            q.push_back(e);
            q.push_back(e);
        end
        op = MD_MULT;
        a  = 32'd3;
        b  = 32'd5;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5)
                chk("b2b_busy5", 32'(busy), 32'd1);
            if (i == 6)
                chk("b2b_gap", 32'(busy), 32'd0);
        end
        chk("b2b_restart", 32'(busy), 32'd1);
        op = MD_NONE;
        wait_idle();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
